// File: rtl/rotary_input_conditioner_if.sv
// Bundle of raw board pins and conditioned event outputs for the rotary
// encoder / push-button front end.
interface rotary_input_conditioner_if;
  // raw asynchronous pins
  logic       rotary_a;
  logic       rotary_b;
  logic       rotary_center;
  logic       btn_west;
  logic       btn_east;
  logic       btn_north;
  // conditioned, registered events
  logic       rot_step;
  logic       rot_dir;
  logic       center_press;
  logic       west_press;
  logic       east_press;
  logic       north_press;
  logic [3:0] btn_level;

  // board / stimulus side: drives the pins, observes the events
  modport master (
    output rotary_a, rotary_b, rotary_center, btn_west, btn_east, btn_north,
    input  rot_step, rot_dir, center_press, west_press, east_press,
           north_press, btn_level
  );

  // conditioner side: samples the pins, produces the events
  modport slave (
    input  rotary_a, rotary_b, rotary_center, btn_west, btn_east, btn_north,
    output rot_step, rot_dir, center_press, west_press, east_press,
           north_press, btn_level
  );
endinterface

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder and push-button conditioner: two-flop synchronisers,
// quadrature detent decoder producing step/direction pulses, and per-switch
// debouncers producing stable levels plus rising-edge press pulses.
module rotary_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                        clk,
  input  logic                        reset,
  rotary_input_conditioner_if.slave   bus
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3
  } state_t;

  // Packed pin order: [5]=north [4]=east [3]=west [2]=center [1]=a [0]=b,
  // so bits [5:2] line up with btn_level {north, east, west, center}.
  logic [5:0] raw;
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic [1:0] code;
  logic [3:0] sw;

  state_t     state_q;
  logic       rot_step_q;
  logic       rot_dir_q;

  logic [3:0]       stable_q, stable_d;
  logic [3:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw  = {bus.btn_north, bus.btn_east, bus.btn_west,
                 bus.rotary_center, bus.rotary_a, bus.rotary_b};
  assign code = sync2_q[1:0];   // {qa, qb}
  assign sw   = sync2_q[5:2];

  // Two-stage synchroniser for every asynchronous pin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Quadrature detent tracker: backtracking retreats one state, illegal
  // jumps abort to IDLE, a step is only emitted on completing the full cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rot_step_q <= 1'b0;
      rot_dir_q  <= 1'b0;
    end else begin
      rot_step_q <= 1'b0;
      case (state_q)
        IDLE: begin
          case (code)
            2'b01:   state_q <= CW1;
            2'b10:   state_q <= CCW1;
            default: state_q <= IDLE;
          endcase
        end
        CW1: begin
          case (code)
            2'b11:   state_q <= CW2;
            2'b01:   state_q <= CW1;
            default: state_q <= IDLE;
          endcase
        end
        CW2: begin
          case (code)
            2'b10:   state_q <= CW3;
            2'b01:   state_q <= CW1;
            2'b11:   state_q <= CW2;
            default: state_q <= IDLE;
          endcase
        end
        CW3: begin
          case (code)
            2'b00: begin
              state_q    <= IDLE;
              rot_step_q <= 1'b1;
              rot_dir_q  <= 1'b1;
            end
            2'b11:   state_q <= CW2;
            2'b10:   state_q <= CW3;
            default: state_q <= IDLE;
          endcase
        end
        CCW1: begin
          case (code)
            2'b11:   state_q <= CCW2;
            2'b10:   state_q <= CCW1;
            default: state_q <= IDLE;
          endcase
        end
        CCW2: begin
          case (code)
            2'b01:   state_q <= CCW3;
            2'b10:   state_q <= CCW1;
            2'b11:   state_q <= CCW2;
            default: state_q <= IDLE;
          endcase
        end
        CCW3: begin
          case (code)
            2'b00: begin
              state_q    <= IDLE;
              rot_step_q <= 1'b1;
              rot_dir_q  <= 1'b0;
            end
            2'b11:   state_q <= CCW2;
            2'b01:   state_q <= CCW3;
            default: state_q <= IDLE;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Debounce next-state: count consecutive disagreeing cycles, accept the new
  // level once the count reaches its limit, any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sw[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
          press_d[i]  = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.rot_step     = rot_step_q;
  assign bus.rot_dir      = rot_dir_q;
  assign bus.center_press = press_q[0];
  assign bus.west_press   = press_q[1];
  assign bus.east_press   = press_q[2];
  assign bus.north_press  = press_q[3];
  assign bus.btn_level    = stable_q;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Directed bench for the rotary/button conditioner with a short debounce.
module tb_rotary_input_conditioner;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   step_cnt;
  int   cpress_cnt;
  int   snap;

  rotary_input_conditioner_if bus ();

  rotary_input_conditioner #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // pulse tallies, sampled on the inactive edge
  initial begin
    step_cnt   = 0;
    cpress_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.rot_step)     step_cnt++;
    if (bus.center_press) cpress_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic a, input logic b);
    bus.rotary_a = a;
    bus.rotary_b = b;
    tick();
  endtask

  task automatic cw_detent();
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.rotary_a      = 1'b0;
    bus.rotary_b      = 1'b0;
    bus.rotary_center = 1'b0;
    bus.btn_west      = 1'b0;
    bus.btn_east      = 1'b0;
    bus.btn_north     = 1'b0;
    tick(3);
    check("rst_step",  32'(bus.rot_step), 32'd0);
    check("rst_dir",   32'(bus.rot_dir), 32'd0);
    check("rst_level", 32'(bus.btn_level), 32'd0);
    check("rst_press", 32'({bus.north_press, bus.east_press,
                            bus.west_press, bus.center_press}), 32'd0);
    reset = 1'b1;
    tick(3);

    // single CW detent, exact latency from the final falling edge
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
    check("cw_lat1", 32'(bus.rot_step), 32'd0);
    tick();
    check("cw_lat2", 32'(bus.rot_step), 32'd0);
    tick();
    check("cw_lat3", 32'(bus.rot_step), 32'd1);
    check("cw_dir",  32'(bus.rot_dir), 32'd1);
    tick();
    check("cw_width", 32'(bus.rot_step), 32'd0);
    tick(3);

    // four back-to-back CW detents
    snap = step_cnt;
    for (int r = 0; r < 4; r++) cw_detent();
    tick(6);
    check("cw_x4", 32'(step_cnt - snap), 32'd4);
    check("cw_x4_dir", 32'(bus.rot_dir), 32'd1);

    // CCW detent with a bounce back to CCW1
    snap = step_cnt;
    set_ab(1'b1, 1'b0);
    set_ab(1'b1, 1'b1);
    set_ab(1'b1, 1'b0);
    set_ab(1'b1, 1'b1);
    set_ab(1'b0, 1'b1);
    set_ab(1'b0, 1'b0);
    tick(2);
    check("ccw_step", 32'(bus.rot_step), 32'd1);
    check("ccw_dir",  32'(bus.rot_dir), 32'd0);
    tick(4);
    check("ccw_cnt",  32'(step_cnt - snap), 32'd1);

    // illegal jumps produce nothing; direction holds
    snap = step_cnt;
    set_ab(1'b1, 1'b1);
    set_ab(1'b0, 1'b0);
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
    tick(6);
    check("illegal_cnt", 32'(step_cnt - snap), 32'd0);
    check("illegal_dir", 32'(bus.rot_dir), 32'd0);

    // center glitch of 10 cycles is discarded
    snap = cpress_cnt;
    bus.rotary_center = 1'b1;
    tick(10);
    bus.rotary_center = 1'b0;
    tick(8);
    check("glitch_press", 32'(cpress_cnt - snap), 32'd0);
    check("glitch_level", 32'(bus.btn_level[0]), 32'd0);

    // held center press: accepted 18 cycles after the rise
    bus.rotary_center = 1'b1;
    tick(17);
    check("ctr_pre",   32'(bus.center_press), 32'd0);
    check("ctr_pre_l", 32'(bus.btn_level[0]), 32'd0);
    tick();
    check("ctr_press", 32'(bus.center_press), 32'd1);
    check("ctr_level", 32'(bus.btn_level), 32'h1);
    tick();
    check("ctr_width", 32'(bus.center_press), 32'd0);
    tick(21);

    // release: level drops after 18 cycles, no press pulse
    snap = cpress_cnt;
    bus.rotary_center = 1'b0;
    tick(17);
    check("rel_pre", 32'(bus.btn_level[0]), 32'd1);
    tick();
    check("rel_level", 32'(bus.btn_level[0]), 32'd0);
    tick(3);
    check("rel_nopress", 32'(cpress_cnt - snap), 32'd0);

    // CW detent completes on the same cycle the north debounce expires
    bus.btn_north = 1'b1;
    tick(12);
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    set_ab(1'b1, 1'b0);
    bus.rotary_a = 1'b0;
    bus.rotary_b = 1'b0;
    tick(3);
    check("sim_step",  32'(bus.rot_step), 32'd1);
    check("sim_north", 32'(bus.north_press), 32'd1);
    check("sim_dir",   32'(bus.rot_dir), 32'd1);
    bus.btn_north = 1'b0;
    tick(22);
    check("sim_rel", 32'(bus.btn_level), 32'd0);

    // reset while FSM is in CW2 and the west counter is at 10
    bus.btn_west = 1'b1;
    tick(8);
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("mid_rst_step",  32'(bus.rot_step), 32'd0);
    check("mid_rst_dir",   32'(bus.rot_dir), 32'd0);
    check("mid_rst_level", 32'(bus.btn_level), 32'd0);
    check("mid_rst_press", 32'(bus.west_press), 32'd0);
    snap = step_cnt;
    reset = 1'b1;
    tick(4);
    set_ab(1'b1, 1'b0);
    set_ab(1'b0, 1'b0);
    tick(11);
    check("post_rst_pre",   32'(bus.west_press), 32'd0);
    tick();
    check("post_rst_press", 32'(bus.west_press), 32'd1);
    check("post_rst_level", 32'(bus.btn_level), 32'h2);
    tick(4);
    check("post_rst_nostep", 32'(step_cnt - snap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
